// File: rtl/alu_op_sequencer.sv
// Multi-cycle sequencer: accepts 16-bit instructions, reads a 16x32 register file,
// drives the ALU opcode/operand interface for one cycle and writes the result back.
module alu_op_sequencer #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_instr_valid,
  input  logic [15:0]       i_instr,
  output logic              o_instr_ready,
  output logic [3:0]        o_alu_opcode,
  output logic [DATA_W-1:0] o_alu_a,
  output logic [DATA_W-1:0] o_alu_b,
  output logic              o_alu_go,
  input  logic [DATA_W-1:0] i_alu_result,
  output logic              o_wb_valid,
  output logic [3:0]        o_wb_addr,
  output logic [DATA_W-1:0] o_wb_data,
  output logic              o_illegal
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_WB
  } state_t;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_XOR = 4'b0110;
  localparam logic [3:0] OP_NOR = 4'b0111;
  localparam logic [3:0] OP_LDI = 4'b1000;

  state_t              r_state;
  state_t              w_next;
  logic [15:0]         r_instr;
  logic [DATA_W-1:0]   r_regs [NREGS];
  logic [3:0]          r_aluOpcode;
  logic [DATA_W-1:0]   r_aluA;
  logic [DATA_W-1:0]   r_aluB;
  logic [3:0]          r_wbAddr;
  logic [DATA_W-1:0]   r_wbData;

  logic [3:0]          w_op;
  logic [3:0]          w_rd;
  logic [3:0]          w_rs;
  logic [3:0]          w_rt;
  logic                w_isAlu;
  logic                w_isLdi;
  logic                w_illegal;
  logic [DATA_W-1:0]   w_rsData;
  logic [DATA_W-1:0]   w_rtData;

  assign w_op = r_instr[15:12];
  assign w_rd = r_instr[11:8];
  assign w_rs = r_instr[7:4];
  assign w_rt = r_instr[3:0];

  always_comb begin
    w_isAlu = 1'b0;
    case (w_op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR: w_isAlu = 1'b1;
      default:                                       w_isAlu = 1'b0;
    endcase
  end

  assign w_isLdi = (w_op == OP_LDI);

  // r0 is hardwired to zero on the read side; its storage is never written.
  assign w_rsData = (w_rs == 4'd0) ? '0 : r_regs[w_rs];
  assign w_rtData = (w_rt == 4'd0) ? '0 : r_regs[w_rt];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_illegal = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_instr_valid) begin
          w_next = S_DECODE;
        end
      end
      S_DECODE: begin
        if (w_isAlu) begin
          w_next = S_EXEC;
        end else if (w_isLdi) begin
          w_next = S_WB;
        end else begin
          w_illegal = 1'b1;
          w_next    = S_IDLE;
        end
      end
      S_EXEC:  w_next = S_WB;
      S_WB:    w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // ALU-facing registers only change when entering EXEC, so they hold outside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr     <= '0;
      r_aluOpcode <= '0;
      r_aluA      <= '0;
      r_aluB      <= '0;
      r_wbAddr    <= '0;
      r_wbData    <= '0;
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_instr_valid) begin
            r_instr <= i_instr;
          end
        end
        S_DECODE: begin
          r_wbAddr <= w_rd;
          if (w_isAlu) begin
            r_aluOpcode <= w_op;
            r_aluA      <= w_rsData;
            r_aluB      <= w_rtData;
          end else if (w_isLdi) begin
            r_wbData <= {{(DATA_W-8){1'b0}}, w_rs, w_rt};
          end
        end
        S_EXEC: begin
          r_wbData <= i_alu_result;
        end
        S_WB: begin
          if (r_wbAddr != 4'd0) begin
            r_regs[r_wbAddr] <= r_wbData;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_instr_ready = (r_state == S_IDLE);
  assign o_alu_go      = (r_state == S_EXEC);
  assign o_wb_valid    = (r_state == S_WB);
  assign o_alu_opcode  = r_aluOpcode;
  assign o_alu_a       = r_aluA;
  assign o_alu_b       = r_aluB;
  assign o_wb_addr     = r_wbAddr;
  assign o_wb_data     = r_wbData;
  assign o_illegal     = w_illegal;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: transaction-level reference model with per-cycle compare,
// directed literal checks and a randomized instruction stream.
module tb_alu_op_sequencer;

  logic        clk;
  logic        rst_n;
  logic        instrValid;
  logic [15:0] instrIn;
  logic        instrReady;
  logic [3:0]  aluOpcode;
  logic [31:0] aluA;
  logic [31:0] aluB;
  logic        aluGo;
  logic [31:0] aluResult;
  logic        wbValid;
  logic [3:0]  wbAddr;
  logic [31:0] wbData;
  logic        illegal;

  int errCount = 0;
  int checkCount = 0;

  alu_op_sequencer #(.DATA_W(32), .NREGS(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_instr_valid(instrValid),
    .i_instr      (instrIn),
    .o_instr_ready(instrReady),
    .o_alu_opcode (aluOpcode),
    .o_alu_a      (aluA),
    .o_alu_b      (aluB),
    .o_alu_go     (aluGo),
    .i_alu_result (aluResult),
    .o_wb_valid   (wbValid),
    .o_wb_addr    (wbAddr),
    .o_wb_data    (wbData),
    .o_illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] aluFn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'h0:    return a + b;
      4'h1:    return a - b;
      4'h4:    return a & b;
      4'h5:    return a | b;
      4'h6:    return a ^ b;
      4'h7:    return ~(a | b);
      default: return 32'h0;
    endcase
  endfunction

  assign aluResult = aluFn(aluOpcode, aluA, aluB);

  // Transaction model: kind 0 = ALU op (ends at step 3), 1 = LDI (ends at step 2), 2 = illegal (step 1).
  bit          mBusy;
  int          mK;
  int          mKind;
  logic [3:0]  mRd;
  logic [3:0]  mOpc;
  logic [31:0] mA, mB, mRes;
  logic [3:0]  mHoldOpc;
  logic [31:0] mHoldA, mHoldB;
  logic [31:0] mRegs [16];

  function automatic int kindOf(input logic [3:0] op);
    if (op inside {4'h0, 4'h1, 4'h4, 4'h5, 4'h6, 4'h7}) return 0;
    if (op == 4'h8) return 1;
    return 2;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mBusy    <= 1'b0;
      mK       <= 0;
      mKind    <= 0;
      mRd      <= '0;
      mOpc     <= '0;
      mA       <= '0;
      mB       <= '0;
      mRes     <= '0;
      mHoldOpc <= '0;
      mHoldA   <= '0;
      mHoldB   <= '0;
      for (int i = 0; i < 16; i++) mRegs[i] <= '0;
    end else if (mBusy) begin
      if (mKind != 2 && mK == (mKind == 0 ? 3 : 2) && mRd != 4'd0) mRegs[mRd] <= mRes;
      if (mKind == 0 && mK == 2) begin
        mHoldOpc <= mOpc;
        mHoldA   <= mA;
        mHoldB   <= mB;
      end
      if (mK == (mKind == 0 ? 3 : (mKind == 1 ? 2 : 1))) mBusy <= 1'b0;
      else mK <= mK + 1;
    end else if (instrValid) begin
      mBusy <= 1'b1;
      mK    <= 1;
      mKind <= kindOf(instrIn[15:12]);
      mRd   <= instrIn[11:8];
      mOpc  <= instrIn[15:12];
      mA    <= mRegs[instrIn[7:4]];
      mB    <= mRegs[instrIn[3:0]];
      if (kindOf(instrIn[15:12]) == 0)
        mRes <= aluFn(instrIn[15:12], mRegs[instrIn[7:4]], mRegs[instrIn[3:0]]);
      else
        mRes <= {24'h0, instrIn[7:0]};
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    logic expGo, expWb, expIll, showNew;
    expGo   = mBusy && mKind == 0 && mK == 2;
    expWb   = mBusy && mKind != 2 && mK == (mKind == 0 ? 3 : 2);
    expIll  = mBusy && mKind == 2 && mK == 1;
    showNew = mBusy && mKind == 0 && mK >= 2;
    checkOutput("instr_ready", instrReady, !mBusy);
    checkOutput("alu_go", aluGo, expGo);
    checkOutput("wb_valid", wbValid, expWb);
    checkOutput("illegal", illegal, expIll);
    checkOutput("alu_opcode", aluOpcode, showNew ? mOpc : mHoldOpc);
    checkOutput("alu_a", aluA, showNew ? mA : mHoldA);
    checkOutput("alu_b", aluB, showNew ? mB : mHoldB);
    if (expWb) begin
      checkOutput("wb_addr", wbAddr, mRd);
      checkOutput("wb_data", wbData, mRes);
    end
  end

  logic        capGo    [1:4];
  logic        capWb    [1:4];
  logic        capIll   [1:4];
  logic        capReady [1:4];
  logic [3:0]  capOpc   [1:4];
  logic [3:0]  capWbAddr[1:4];
  logic [31:0] capWbData[1:4];

  task automatic waitReady();
    int budget = 0;
    while (!instrReady && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (!instrReady) checkOutput("ready_timeout", 64'd0, 64'd1);
  endtask

  // Issues one instruction from a negedge and records steps 1..4 after the accept edge.
  task automatic applyStimulus(input logic [15:0] ins);
    waitReady();
    instrIn    = ins;
    instrValid = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) instrValid = 1'b0;
      capGo[k]     = aluGo;
      capWb[k]     = wbValid;
      capIll[k]    = illegal;
      capReady[k]  = instrReady;
      capOpc[k]    = aluOpcode;
      capWbAddr[k] = wbAddr;
      capWbData[k] = wbData;
    end
  endtask

  task automatic ldi(input logic [3:0] rd, input logic [7:0] imm);
    applyStimulus({4'h8, rd, imm});
  endtask

  task automatic aluOp(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs, input logic [3:0] rt);
    applyStimulus({op, rd, rs, rt});
  endtask

  task automatic shl(input logic [3:0] r, input int n);
    for (int i = 0; i < n; i++) aluOp(4'h0, r, r, r);
  endtask

  logic [3:0] legalOps   [8] = '{4'h0, 4'h1, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h8};
  logic [3:0] illegalOps [9] = '{4'h2, 4'h3, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};

  initial begin
    int accepts;
    logic [11:0] fields;
    logic [3:0] op;
    rst_n      = 1'b1;
    instrValid = 1'b0;
    instrIn    = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_ready", instrReady, 1'b1);
    checkOutput("reset_wb_data", wbData, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Build r1 = F0F0F0F0 and r2 = FF00FF00 from 8-bit immediates by doubling and OR.
    ldi(4'd1, 8'hF0);
    aluOp(4'h5, 4'd7, 4'd1, 4'd0);
    shl(4'd1, 8);
    aluOp(4'h5, 4'd1, 4'd1, 4'd7);
    aluOp(4'h5, 4'd7, 4'd1, 4'd0);
    shl(4'd1, 16);
    aluOp(4'h5, 4'd1, 4'd1, 4'd7);
    ldi(4'd2, 8'hFF);
    shl(4'd2, 8);
    aluOp(4'h5, 4'd7, 4'd2, 4'd0);
    shl(4'd2, 16);
    aluOp(4'h5, 4'd2, 4'd2, 4'd7);
    checkOutput("preload_r2", capWbData[3], 32'hFF00_FF00);

    applyStimulus(16'h4312);
    checkOutput("and_go_step1", capGo[1], 1'b0);
    checkOutput("and_go_step2", capGo[2], 1'b1);
    checkOutput("and_opcode", capOpc[2], 4'h4);
    checkOutput("and_wb_step3", capWb[3], 1'b1);
    checkOutput("and_wb_addr", capWbAddr[3], 4'd3);
    checkOutput("and_wb_data", capWbData[3], 32'hF000_F000);
    checkOutput("and_ready_step4", capReady[4], 1'b1);
    applyStimulus(16'h5812);
    checkOutput("or_data", capWbData[3], 32'hFFF0_FFF0);
    applyStimulus(16'h6912);
    checkOutput("xor_data", capWbData[3], 32'h0FF0_0FF0);
    applyStimulus(16'h7A12);
    checkOutput("nor_data", capWbData[3], 32'h000F_000F);
    applyStimulus(16'h7B00);
    ldi(4'd12, 8'h01);
    applyStimulus(16'h0DBC);
    checkOutput("add_wrap", capWbData[3], 32'h0);

    ldi(4'd5, 8'hA7);
    checkOutput("ldi_wb_step2", capWb[2], 1'b1);
    checkOutput("ldi_wb_data", capWbData[2], 32'h0000_00A7);
    checkOutput("ldi_ready_step3", capReady[3], 1'b1);
    applyStimulus(16'h4655);
    checkOutput("and_r5_r5", capWbData[3], 32'h0000_00A7);

    applyStimulus(16'hF123);
    checkOutput("ill_step1", capIll[1], 1'b1);
    checkOutput("ill_step2", capIll[2], 1'b0);
    checkOutput("ill_no_go", capGo[1] | capGo[2] | capGo[3] | capGo[4], 1'b0);
    checkOutput("ill_no_wb", capWb[1] | capWb[2] | capWb[3] | capWb[4], 1'b0);
    checkOutput("ill_ready_step2", capReady[2], 1'b1);

    ldi(4'd0, 8'h55);
    checkOutput("r0_wb_valid", capWb[2], 1'b1);
    checkOutput("r0_wb_addr", capWbAddr[2], 4'd0);
    applyStimulus(16'h5100);
    checkOutput("r0_reads_zero", capWbData[3], 32'h0);

    // Valid held high: one accept every fourth cycle.
    waitReady();
    instrIn    = 16'h0E12;
    instrValid = 1'b1;
    accepts    = 0;
    for (int i = 0; i < 16; i++) begin
      if (instrReady) accepts++;
      @(negedge clk);
    end
    instrValid = 1'b0;
    checkOutput("b2b_accepts", accepts, 4);

    // Reset asserted during EXEC aborts the op and clears everything at once.
    waitReady();
    instrIn    = 16'h5312;
    instrValid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instrValid = 1'b0;
    @(negedge clk);
    checkOutput("rst_exec_go", aluGo, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_ready", instrReady, 1'b1);
    checkOutput("rst_go", aluGo, 1'b0);
    checkOutput("rst_wb_valid", wbValid, 1'b0);
    checkOutput("rst_opcode", aluOpcode, 4'h0);
    checkOutput("rst_alu_a", aluA, 32'h0);
    checkOutput("rst_alu_b", aluB, 32'h0);
    checkOutput("rst_wb_addr", wbAddr, 4'h0);
    checkOutput("rst_wb_data", wbData, 32'h0);
    checkOutput("rst_illegal", illegal, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(16'h5322);
    checkOutput("rst_cleared_regs", capWbData[3], 32'h0);

    // Randomized stream: mostly legal ops, some illegal, random idle gaps.
    for (int n = 0; n < 200; n++) begin
      fields = 12'($urandom);
      if ($urandom_range(0, 9) == 0) op = illegalOps[$urandom_range(0, 8)];
      else op = legalOps[$urandom_range(0, 7)];
      applyStimulus({op, fields});
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Multi-cycle control sequencer that produces the 4-bit ALU opcode and operands consumed by the ALU's arithmetic and logic units. It accepts 16-bit instructions over a valid/ready handshake, reads two operands from an internal 16×32 register file, drives the ALU, captures the ALU result and writes it back. It is the issuing end of the opcode interface whose receiving end is the ALU opcode mux.

## Interface
- `DATA_W`, 32, operand/result width
- `NREGS`, 16, register count (address width 4)
- `clk` in 1: rising-edge clock
- `rst_n` in 1: asynchronous, active-low reset
- `instr_valid` in 1: instruction offered
- `instr` in 16: `[15:12]` op, `[11:8]` rd, `[7:4]` rs, `[3:0]` rt
- `instr_ready` out 1: sequencer can accept
- `alu_opcode` out 4: opcode to ALU
- `alu_a`, `alu_b` out DATA_W: operands to ALU
- `alu_go` out 1: opcode/operands valid (EXEC only)
- `alu_result` in DATA_W: combinational ALU result
- `wb_valid` out 1: one-cycle writeback pulse
- `wb_addr` out 4 / `wb_data` out DATA_W: writeback target and value
- `illegal` out 1: one-cycle pulse on an undefined op

## Operation
- Op map (`instr[15:12]`):
  - `0000` ADD; `0001` SUB; `0100` AND; `0101` OR; `0110` XOR; `0111` NOR.
  - ALU ops pass through unchanged on `alu_opcode`.
  - `1000` LDI: rd ← zero-extended `{rs,rt}` (8 bits); no ALU use.
  - All other ops are illegal.
- Register file: r0 always reads 0. Writes to r0 are discarded, but `wb_valid` still pulses with `wb_addr`=0.
- FSM states:
  - IDLE: `instr_ready`=1. On `instr_valid`&`instr_ready`, latch `instr` and go to DECODE.
  - DECODE: read rs/rt into the operand registers.
    - Illegal op: pulse `illegal` and go to IDLE.
    - LDI: go to WB.
    - Otherwise: go to EXEC.
  - EXEC: `alu_go`=1. `alu_opcode`, `alu_a` and `alu_b` are stable for the whole cycle. Sample `alu_result` at the closing edge, then go to WB.
  - WB: `wb_valid`=1 with `wb_addr`=rd and `wb_data`=captured value. Write the register file at the closing edge, then go to IDLE.
- `alu_opcode`, `alu_a` and `alu_b` hold their last values outside EXEC. Consumers must qualify them with `alu_go`.
- No masking or extension of the result. The full DATA_W `alu_result` is written.

## Timing
- Reset (async assert, sync deassert inside the clock domain):
  - State returns to IDLE.
  - All registers are cleared to 0.
  - `instr_ready`=1; `alu_opcode`=0; `alu_a`=`alu_b`=0; `alu_go`=0; `wb_valid`=0; `wb_addr`=0; `wb_data`=0; `illegal`=0.
- Reset mid-operation aborts the instruction with no writeback. Register contents are cleared.
- Handshake at edge T:
  - ALU op: DECODE in cycle T+1, EXEC in T+2, WB in T+3, `instr_ready` high again in T+4. Throughput is one ALU op per 4 cycles.
  - LDI: WB in T+2, ready in T+3.
  - Illegal op: `illegal` pulses in T+1, ready in T+2.
- `instr_ready` is low in every non-IDLE state. `instr_valid` offered while busy is ignored, not lost from the producer's view: the producer must hold it until accepted.
- Read-after-write: a write in WB at edge E is visible to the DECODE read of the next instruction, because that DECODE occurs at or after E+2.
- Writeback to the same register as an operand uses the old value. Operands are latched in DECODE.

## Test plan
- Reset, then AND: preload r1=0xF0F0_F0F0 and r2=0xFF00_FF00 via LDI chains or a backdoor, then issue `0100_0011_0001_0010`.
  - `alu_go` is high exactly 2 cycles after accept with `alu_opcode`=0100.
  - With a model ALU, `wb_valid` occurs at T+3 with `wb_addr`=3 and `wb_data`=0xF000_F000.
- Logic sweep (OR/XOR/NOR) on the same operands gives 0xFFF0_FFF0, 0x0FF0_0FF0 and 0x000F_000F. ADD of 0xFFFF_FFFF+1 gives 0 (wraps, no carry out).
- LDI to r5 with imm 0xA7: `wb_data`=0x0000_00A7 at T+2. A subsequent AND r6=r5&r5 reads 0xA7.
- Illegal op `1111`: `illegal` pulses once at T+1, with no `alu_go` and no `wb_valid`. `instr_ready` returns at T+2.
- Write to r0 (LDI 0x55 to r0): `wb_valid` fires, then OR r1=r0|r0 yields 0.
- Back-to-back `instr_valid` held high: exactly one accept per 4 cycles. Assert `rst_n` low during EXEC: there is no `wb_valid`, all outputs read 0 immediately, and `instr_ready`=1.
